// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts instruction words, owns the register file and flags.
// Optional ALU_ISSUE_OVERLAP_EN: accept the next instruction during write-back (1 instruction / 2 cycles).
module alu_issue_ctrl #(
  parameter int          DW      = 8,
  parameter int          RA_W    = 2,
  parameter logic [7:0]  OPC_LDI = 8'h06
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [23:0]     instr,
  output logic [7:0]      alu_opcode,
  output logic [DW-1:0]   alu_op1,
  output logic [DW-1:0]   alu_op2,
  input  logic [DW-1:0]   alu_dout,
  input  logic [7:0]      alu_eflags,
  output logic [7:0]      flags_q,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_rd,
  output logic [DW-1:0]   wb_data,
  output logic            illegal,
  input  logic [RA_W-1:0] dbg_sel,
  output logic [DW-1:0]   dbg_data,
  output logic [1:0]      dbg_state
);

  localparam int NREG = 2 ** RA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Handshake: a word transfers on a rising edge where instr_valid && instr_ready;
  // instr is ignored on every other edge, whatever its value.
  logic accept;

  logic [7:0]      opc_q;
  logic [RA_W-1:0] rd_q, ra_q, rb_q;
  logic [7:0]      imm_q;
  logic            flags_we;

  logic [DW-1:0] regs [NREG];

  assign accept    = instr_valid && instr_ready;
  assign wb_rd     = rd_q;
  assign dbg_data  = regs[dbg_sel];
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    wb_data     = '0;
    illegal     = 1'b0;
    flags_we    = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        state_d = IDLE;
`ifdef ALU_ISSUE_OVERLAP_EN
        instr_ready = 1'b1;
        if (instr_valid) state_d = EXEC;
`endif
        // ALU inputs were registered at the end of EXEC, so dout/eflags are valid here.
        if (opc_q == OPC_LDI) begin
          wb_valid = 1'b1;
          wb_data  = DW'(imm_q);
        end else begin
          case (opc_q)
            8'h00: ;
            8'h01: begin
              wb_valid = 1'b1;
              wb_data  = alu_dout;
              flags_we = 1'b1;
            end
            8'h02, 8'h04, 8'h05: begin
              wb_valid = 1'b1;
              wb_data  = alu_dout;
            end
            8'h03: flags_we = 1'b1;
            default: illegal = 1'b1;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opc_q   <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opc_q <= instr[23:16];
        rd_q  <= instr[15:14];
        ra_q  <= instr[13:12];
        rb_q  <= instr[11:10];
        imm_q <= instr[7:0];
      end
    end
  end

  // Operands are read in EXEC, after any write-back of the previous instruction has landed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
    end else if (state_q == EXEC) begin
      alu_opcode <= opc_q;
      alu_op1    <= regs[ra_q];
      alu_op2    <= regs[rb_q];
    end else if (state_q == WB) begin
      alu_opcode <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      flags_q <= '0;
    end else begin
      if (wb_valid) regs[wb_rd] <= wb_data;
      if (flags_we) flags_q <= alu_eflags;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a shadow register file.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instr;
  logic [7:0]  alu_opcode;
  logic [7:0]  alu_op1, alu_op2;
  logic [7:0]  alu_dout;
  logic [7:0]  alu_eflags;
  logic [7:0]  flags_q;
  logic        wb_valid;
  logic [1:0]  wb_rd;
  logic [7:0]  wb_data;
  logic        illegal;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_regs [4];

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_dout(alu_dout), .alu_eflags(alu_eflags),
    .flags_q(flags_q), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // behavioural ALU: flags {zero, neg, ovf, carry}; 8'hA5 marks "undefined" flags
  logic [8:0]  t9;
  logic [15:0] p16;
  always_comb begin
    alu_dout   = '0;
    alu_eflags = 8'hA5;
    t9         = '0;
    p16        = '0;
    case (alu_opcode)
      8'h01: begin
        t9         = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_dout   = t9[7:0];
        alu_eflags = {4'h0, t9[7:0] == 8'h00, t9[7],
                      (alu_op1[7] == alu_op2[7]) && (t9[7] != alu_op1[7]), t9[8]};
      end
      8'h02: begin
        p16      = alu_op1 * alu_op2;
        alu_dout = p16[7:0];
      end
      8'h03: begin
        t9         = {1'b0, alu_op1} - {1'b0, alu_op2};
        alu_eflags = {4'h0, t9[7:0] == 8'h00, t9[7],
                      (alu_op1[7] != alu_op2[7]) && (t9[7] != alu_op1[7]), t9[8]};
      end
      8'h04: alu_dout = alu_op1 << alu_op2[2:0];
      8'h05: alu_dout = alu_op1 >> alu_op2[2:0];
      default: alu_dout = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] enc(input logic [7:0] opc, input logic [1:0] rd,
                                      input logic [1:0] ra, input logic [1:0] rb,
                                      input logic [7:0] imm);
    return {opc, rd, ra, rb, 2'b00, imm};
  endfunction

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, exp_regs[i]);
    end
  endtask

  // driver: present a word and hold it until the handshake edge
  task automatic send(input logic [23:0] w);
    int t;
    t = 0;
    instr       = w;
    instr_valid = 1'b1;
    while (!instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_accept", instr_ready, 1'b1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = $urandom;
  endtask

  // one instruction: EXEC then WB expectations; post=1 also checks flags and regs after WB
  task automatic exec_chk(input string tag, input logic [23:0] w, input bit exp_wb,
                          input logic [7:0] exp_data, input bit exp_ill,
                          input logic [7:0] exp_flags, input bit post);
    send(w);
    @(negedge clk);
    check({tag, "_exec_wb_valid"}, wb_valid, 1'b0);
    check({tag, "_exec_illegal"}, illegal, 1'b0);
    @(negedge clk);
    check({tag, "_wb_valid"}, wb_valid, exp_wb);
    check({tag, "_illegal"}, illegal, exp_ill);
    check({tag, "_alu_opcode"}, alu_opcode, w[23:16]);
    if (exp_wb) begin
      check({tag, "_wb_rd"}, wb_rd, w[15:14]);
      check({tag, "_wb_data"}, wb_data, exp_data);
      exp_regs[w[15:14]] = exp_data;
    end
    if (post) begin
      @(posedge clk);
      #1;
      check({tag, "_flags"}, flags_q, exp_flags);
      chk_regs(tag);
    end
  endtask

  int acc [3];
  int n_acc;
  int gap;

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    dbg_sel = '0;
    for (int i = 0; i < 4; i++) exp_regs[i] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_ready", instr_ready, 1'b1);
    check("rst_state", dbg_state, 2'd0);
    check("rst_alu_opcode", alu_opcode, 8'h00);
    check("rst_alu_op1", alu_op1, 8'h00);
    check("rst_flags", flags_q, 8'h00);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    chk_regs("rst");

    // dirty state, then reset in the middle of an ADD
    exec_chk("ldi80", enc(8'h06, 2'd0, 2'd0, 2'd0, 8'h80), 1, 8'h80, 0, 8'h00, 1);
    exec_chk("add_c", enc(8'h01, 2'd1, 2'd0, 2'd0, 8'h00), 1, 8'h00, 0, 8'h0B, 1);
    send(enc(8'h01, 2'd2, 2'd0, 2'd0, 8'h00));
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("midrst_wb_valid", wb_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_regs[i] = 8'h00;
    check("midrst_ready", instr_ready, 1'b1);
    check("midrst_flags", flags_q, 8'h00);
    check("midrst_alu_opcode", alu_opcode, 8'h00);
    @(negedge clk);
    check("midrst_no_wb", wb_valid, 1'b0);
    chk_regs("midrst");
    @(negedge clk);

    // LDI / ADD with signed overflow: 7F + 01 = 80, flags ovf|neg
    exec_chk("ldi_r0", enc(8'h06, 2'd0, 2'd0, 2'd0, 8'h7F), 1, 8'h7F, 0, 8'h00, 1);
    exec_chk("ldi_r1", enc(8'h06, 2'd1, 2'd0, 2'd0, 8'h01), 1, 8'h01, 0, 8'h00, 1);
    exec_chk("add", enc(8'h01, 2'd2, 2'd0, 2'd1, 8'h00), 1, 8'h80, 0, 8'h06, 0);
    @(negedge clk);
    check("add_opcode_cleared", alu_opcode, 8'h00);
    check("add_flags", flags_q, 8'h06);
    chk_regs("add");

    // CMP r1,r0: 01 - 7F -> borrow|neg, no register write
    exec_chk("cmp", enc(8'h03, 2'd3, 2'd1, 2'd0, 8'h00), 0, 8'h00, 0, 8'h05, 1);

    // MUL / LSH / RSH with r0=10, r1=03; flags stay at the CMP value
    exec_chk("ldi_r0b", enc(8'h06, 2'd0, 2'd0, 2'd0, 8'h10), 1, 8'h10, 0, 8'h05, 1);
    exec_chk("ldi_r1b", enc(8'h06, 2'd1, 2'd0, 2'd0, 8'h03), 1, 8'h03, 0, 8'h05, 1);
    exec_chk("mul", enc(8'h02, 2'd3, 2'd0, 2'd1, 8'h00), 1, 8'h30, 0, 8'h05, 1);
    exec_chk("lsh", enc(8'h04, 2'd2, 2'd0, 2'd1, 8'h00), 1, 8'h80, 0, 8'h05, 1);
    exec_chk("rsh", enc(8'h05, 2'd2, 2'd0, 2'd1, 8'h00), 1, 8'h02, 0, 8'h05, 1);

    // unsupported opcode and NOP
    exec_chk("illegal", enc(8'h7F, 2'd3, 2'd0, 2'd1, 8'hEE), 0, 8'h00, 1, 8'h05, 1);
    exec_chk("nop", enc(8'h00, 2'd3, 2'd0, 2'd1, 8'hEE), 0, 8'h00, 0, 8'h05, 1);

    // back-to-back RAW: r1 = r0+r0 = 02, r2 = r1+r1 = 04
    exec_chk("raw_ldi", enc(8'h06, 2'd0, 2'd0, 2'd0, 8'h01), 1, 8'h01, 0, 8'h05, 1);
    exec_chk("raw_add1", enc(8'h01, 2'd1, 2'd0, 2'd0, 8'h00), 1, 8'h02, 0, 8'h00, 0);
    exec_chk("raw_add2", enc(8'h01, 2'd2, 2'd1, 2'd1, 8'h00), 1, 8'h04, 0, 8'h00, 1);

    // accept cadence with instr_valid held high
`ifdef ALU_ISSUE_OVERLAP_EN
    gap = 2;
`else
    gap = 3;
`endif
    @(negedge clk);
    n_acc = 0;
    instr = enc(8'h06, 2'd3, 2'd0, 2'd0, 8'h11);
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (instr_ready && n_acc < 3) begin
        acc[n_acc] = c;
        n_acc++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("cadence_count", n_acc, 3);
    check("cadence_gap1", acc[1] - acc[0], gap);
    check("cadence_gap2", acc[2] - acc[1], gap);
    repeat (3) @(negedge clk);
    exp_regs[3] = 8'h11;
    check("cadence_idle", instr_ready, 1'b1);
    chk_regs("cadence");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
